pllrefcs_sel_ctrl: RTL and testbench

Reference-clock supervisor that drives the SEL input of the PLL reference clock mux. It oversamples both candidate reference clocks in the system clock domain, counts edges per measurement window, and qualifies each source with hysteresis. It selects the preferred source, fails over to the other source when the active one is lost, and reverts when the preferred source recovers. The PLL is held in reset around every change of SEL so that it relocks cleanly.

---
 rtl/pllrefcs_sel_ctrl_if.sv | 26 ++
 rtl/pllrefcs_sel_ctrl.sv | 154 +++++++++++++++
 tb/tb_pllrefcs_sel_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pllrefcs_sel_ctrl_if.sv
// Signal bundle between the reference-clock supervisor and its environment.
// The slave modport is the supervisor's view; master is the driving side.
interface pllrefcs_sel_ctrl_if;
    logic       refclk0_i;
    logic       refclk1_i;
    logic       prefer_i;
    logic       force_en_i;
    logic       force_sel_i;
    logic       sel_o;
    logic       clk0_ok_o;
    logic       clk1_ok_o;
    logic       no_ref_o;
    logic       pll_rst_o;
    logic       switching_o;
    logic [7:0] switch_cnt_o;

    modport master (
        output refclk0_i, refclk1_i, prefer_i, force_en_i, force_sel_i,
        input  sel_o, clk0_ok_o, clk1_ok_o, no_ref_o, pll_rst_o, switching_o, switch_cnt_o
    );

    modport slave (
        input  refclk0_i, refclk1_i, prefer_i, force_en_i, force_sel_i,
        output sel_o, clk0_ok_o, clk1_ok_o, no_ref_o, pll_rst_o, switching_o, switch_cnt_o
    );
endinterface

// File: rtl/pllrefcs_sel_ctrl.sv
// PLL reference-clock supervisor: qualifies both refclks by edge count per
// window and drives the mux select, holding the PLL in reset around each change.
//
// state  | meaning
// INIT   | no source qualified yet, PLL held in reset
// SWITCH | SEL just changed, PLL held in reset for HOLD_CYCLES
// RUN    | PLL running, watching for fail-over / revert / force
module pllrefcs_sel_ctrl #(
    parameter int WINDOW       = 256,
    parameter int MIN_EDGES    = 16,
    parameter int MAX_EDGES    = 96,
    parameter int GOOD_WINDOWS = 2,
    parameter int HOLD_CYCLES  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pllrefcs_sel_ctrl_if.slave bus
);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(WINDOW + 1);
    localparam int GW = $clog2(GOOD_WINDOWS + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [EW-1:0] MIN_L     = EW'(MIN_EDGES);
    localparam logic [EW-1:0] MAX_L     = EW'(MAX_EDGES);
    localparam logic [GW-1:0] GOOD_L    = GW'(GOOD_WINDOWS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_SWITCH, ST_RUN} state_t;

    logic [1:0]         s1_q, s2_q, prev_q;
    logic [WW-1:0]      win_q, win_d;
    logic [1:0][EW-1:0] ecnt_q, ecnt_d, ecnt_tot;
    logic [1:0][GW-1:0] gcnt_q, gcnt_d;
    logic [1:0]         ok_q, ok_d, edge_det, good_win;
    logic               boundary;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pll_rst_q, switching_q, no_ref_q;
    logic               prefer_ok, active_ok, other_ok, init_tgt, run_tgt;

    assign boundary = (win_q == WIN_LAST);
    assign win_d    = boundary ? '0 : win_q + WW'(1);

    // The edge seen on the boundary cycle still belongs to the closing window.
    always_comb begin
        edge_det = s2_q & ~prev_q;
        ecnt_tot = ecnt_q;
        ecnt_d   = ecnt_q;
        gcnt_d   = gcnt_q;
        ok_d     = ok_q;
        good_win = '0;
        for (int i = 0; i < 2; i++) begin
            if (ecnt_q[i] != '1) ecnt_tot[i] = ecnt_q[i] + EW'(edge_det[i]);
            good_win[i] = (ecnt_tot[i] >= MIN_L) && (ecnt_tot[i] <= MAX_L);
            ecnt_d[i]   = boundary ? '0 : ecnt_tot[i];
            if (boundary) begin
                if (good_win[i]) begin
                    gcnt_d[i] = (gcnt_q[i] == GOOD_L) ? GOOD_L : gcnt_q[i] + GW'(1);
                    ok_d[i]   = (gcnt_d[i] == GOOD_L);
                end else begin
                    gcnt_d[i] = '0;
                    ok_d[i]   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        prefer_ok = bus.prefer_i ? ok_q[1] : ok_q[0];
        active_ok = sel_q ? ok_q[1] : ok_q[0];
        other_ok  = sel_q ? ok_q[0] : ok_q[1];
        init_tgt  = bus.force_en_i ? bus.force_sel_i : (prefer_ok ? bus.prefer_i : ok_q[1]);
        run_tgt   = sel_q;
        if (bus.force_en_i)                         run_tgt = bus.force_sel_i;
        else if (!active_ok && other_ok)            run_tgt = ~sel_q;
        else if (sel_q != bus.prefer_i && prefer_ok) run_tgt = bus.prefer_i;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (|ok_q) begin
                    sel_d   = init_tgt;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (hold_q == '0) state_d = ST_RUN;
                else              hold_d  = hold_q - HW'(1);
            end
            ST_RUN: begin
                if (run_tgt != sel_q) begin
                    sel_d   = run_tgt;
                    cnt_d   = cnt_q + 8'd1;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_SWITCH;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
            win_q       <= '0;
            ecnt_q      <= '0;
            gcnt_q      <= '0;
            ok_q        <= '0;
            state_q     <= ST_INIT;
            sel_q       <= 1'b0;
            hold_q      <= '0;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            switching_q <= 1'b0;
            no_ref_q    <= 1'b1;
        end else begin
            s1_q        <= {bus.refclk1_i, bus.refclk0_i};
            s2_q        <= s1_q;
            prev_q      <= s2_q;
            win_q       <= win_d;
            ecnt_q      <= ecnt_d;
            gcnt_q      <= gcnt_d;
            ok_q        <= ok_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d != ST_RUN);
            switching_q <= (state_d == ST_SWITCH);
            no_ref_q    <= ~|ok_d;
        end
    end

    assign bus.sel_o        = sel_q;
    assign bus.clk0_ok_o    = ok_q[0];
    assign bus.clk1_ok_o    = ok_q[1];
    assign bus.no_ref_o     = no_ref_q;
    assign bus.pll_rst_o    = pll_rst_q;
    assign bus.switching_o  = switching_q;
    assign bus.switch_cnt_o = cnt_q;
endmodule

// File: tb/tb_pllrefcs_sel_ctrl.sv
// Directed bench for pllrefcs_sel_ctrl: start-up selection, fail-over, revert,
// forced selection, loss of both sources and reset during a switch.
module tb_pllrefcs_sel_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   mode0  = 0;
    int   mode1  = 0;
    logic [7:0] ph0 = '0;
    logic [7:0] ph1 = '0;

    pllrefcs_sel_ctrl_if bus ();

    pllrefcs_sel_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // mode 2 -> CLK/2, mode 4 -> CLK/4, anything else holds the level
    always @(negedge clk) begin
        ph0 = ph0 + 8'd1;
        ph1 = ph1 + 8'd1;
        if (mode0 == 2 || (mode0 == 4 && ph0[0])) bus.refclk0_i = ~bus.refclk0_i;
        if (mode1 == 2 || (mode1 == 4 && ph1[0])) bus.refclk1_i = ~bus.refclk1_i;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic to_cyc(input int t);
        step(t - cyc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.refclk0_i   = 1'b0;
        bus.refclk1_i   = 1'b0;
        bus.prefer_i    = 1'b1;
        bus.force_en_i  = 1'b0;
        bus.force_sel_i = 1'b0;
        mode0 = 4;
        mode1 = 4;
        step(4);
        chk("rst_sel", bus.sel_o, 0);
        chk("rst_ok0", bus.clk0_ok_o, 0);
        chk("rst_ok1", bus.clk1_ok_o, 0);
        chk("rst_noref", bus.no_ref_o, 1);
        chk("rst_pllrst", bus.pll_rst_o, 1);
        chk("rst_switching", bus.switching_o, 0);
        chk("rst_cnt", bus.switch_cnt_o, 0);

        // start-up: both at CLK/4, PREFER=1
        rst = 1'b0;
        cyc = 0;
        to_cyc(511);
        chk("init_ok1_early", bus.clk1_ok_o, 0);
        chk("init_pllrst_early", bus.pll_rst_o, 1);
        to_cyc(512);
        chk("init_ok0", bus.clk0_ok_o, 1);
        chk("init_ok1", bus.clk1_ok_o, 1);
        chk("init_noref", bus.no_ref_o, 0);
        chk("init_sel_before", bus.sel_o, 0);
        to_cyc(513);
        chk("init_sel", bus.sel_o, 1);
        chk("init_switching", bus.switching_o, 1);
        chk("init_cnt", bus.switch_cnt_o, 0);
        to_cyc(576);
        chk("init_hold_last", bus.pll_rst_o, 1);
        to_cyc(577);
        chk("init_pllrst_low", bus.pll_rst_o, 0);
        chk("init_switching_low", bus.switching_o, 0);
        chk("init_cnt_run", bus.switch_cnt_o, 0);

        // fail-over: stop REFCLK1
        to_cyc(600);
        mode1 = 0;
        to_cyc(1023);
        chk("fo_ok1_held", bus.clk1_ok_o, 1);
        to_cyc(1024);
        chk("fo_ok1_drop", bus.clk1_ok_o, 0);
        chk("fo_sel_before", bus.sel_o, 1);
        to_cyc(1025);
        chk("fo_sel", bus.sel_o, 0);
        chk("fo_cnt", bus.switch_cnt_o, 1);
        chk("fo_pllrst", bus.pll_rst_o, 1);
        to_cyc(1088);
        chk("fo_hold_last", bus.pll_rst_o, 1);
        to_cyc(1089);
        chk("fo_pllrst_low", bus.pll_rst_o, 0);

        // revert: restart REFCLK1
        to_cyc(1100);
        mode1 = 4;
        to_cyc(1535);
        chk("rv_ok1_early", bus.clk1_ok_o, 0);
        to_cyc(1536);
        chk("rv_ok1", bus.clk1_ok_o, 1);
        chk("rv_sel_before", bus.sel_o, 0);
        to_cyc(1537);
        chk("rv_sel", bus.sel_o, 1);
        chk("rv_cnt", bus.switch_cnt_o, 2);
        chk("rv_switching", bus.switching_o, 1);

        // force during SWITCH is deferred until RUN
        to_cyc(1540);
        bus.force_en_i  = 1'b1;
        bus.force_sel_i = 1'b0;
        to_cyc(1600);
        chk("fc_sel_in_switch", bus.sel_o, 1);
        chk("fc_switching", bus.switching_o, 1);
        to_cyc(1601);
        chk("fc_sel_run_entry", bus.sel_o, 1);
        chk("fc_pllrst_low", bus.pll_rst_o, 0);
        to_cyc(1602);
        chk("fc_sel", bus.sel_o, 0);
        chk("fc_cnt", bus.switch_cnt_o, 3);
        to_cyc(1610);
        bus.force_en_i = 1'b0;
        to_cyc(1666);
        chk("fc_release_sel_hold", bus.sel_o, 0);
        to_cyc(1667);
        chk("fc_release_sel", bus.sel_o, 1);
        chk("fc_release_cnt", bus.switch_cnt_o, 4);

        // both sources lost
        to_cyc(1750);
        mode0 = 0;
        mode1 = 0;
        to_cyc(2047);
        chk("nr_ok0_held", bus.clk0_ok_o, 1);
        chk("nr_ok1_held", bus.clk1_ok_o, 1);
        to_cyc(2048);
        chk("nr_ok0", bus.clk0_ok_o, 0);
        chk("nr_ok1", bus.clk1_ok_o, 0);
        to_cyc(2060);
        chk("nr_noref", bus.no_ref_o, 1);
        chk("nr_sel", bus.sel_o, 1);
        chk("nr_cnt", bus.switch_cnt_o, 4);
        chk("nr_pllrst", bus.pll_rst_o, 0);

        // REFCLK0 too fast, PREFER=0
        rst = 1'b1;
        mode0 = 2;
        mode1 = 4;
        bus.prefer_i = 1'b0;
        step(3);
        chk("r2_cnt", bus.switch_cnt_o, 0);
        chk("r2_pllrst", bus.pll_rst_o, 1);
        rst = 1'b0;
        cyc = 0;
        to_cyc(512);
        chk("fast_ok0", bus.clk0_ok_o, 0);
        chk("fast_ok1", bus.clk1_ok_o, 1);
        chk("fast_noref", bus.no_ref_o, 0);
        to_cyc(513);
        chk("fast_sel", bus.sel_o, 1);
        chk("fast_cnt", bus.switch_cnt_o, 0);

        // reset in the middle of SWITCH
        to_cyc(530);
        rst = 1'b1;
        step(1);
        chk("mr_sel", bus.sel_o, 0);
        chk("mr_pllrst", bus.pll_rst_o, 1);
        chk("mr_switching", bus.switching_o, 0);
        chk("mr_ok1", bus.clk1_ok_o, 0);
        chk("mr_noref", bus.no_ref_o, 1);
        rst = 1'b0;
        cyc = 0;
        to_cyc(511);
        chk("mr_ok1_early", bus.clk1_ok_o, 0);
        to_cyc(600);
        chk("mr_ok0_late", bus.clk0_ok_o, 0);
        chk("mr_sel_late", bus.sel_o, 1);
        chk("mr_pllrst_late", bus.pll_rst_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
